// File: rtl/comp_mult_scoreboard.sv
`default_nettype none
//============================================================================
// Module   : comp_mult_scoreboard
// Purpose  : Multi-channel self-checking scoreboard for complex multipliers.
//            Accepted operand sets {x1,y1,x2,y2} go into one shared queue.
//            Every DUT result channel has its own read pointer, so channels
//            may consume the same entry in different cycles. Each sampled
//            result is compared exactly against
//                xr = x1*x2 - y1*y2,  yr = x1*y2 + y1*x2.
//            Sticky error/overflow flags and saturating counters let a bench
//            run unattended. The block observes only; it drives nothing
//            back into the DUT handshakes.
// Ports    : clk          system clock
//            rst_n        asynchronous reset, active low
//            sw_rst_i     synchronous software clear, active high; it wins
//                         over a push or sample in the same cycle
//            op_val_i     operand valid
//            op_rdy_i     operand ready (push = valid & ready)
//            op_data_i    operands {x1,y1,x2,y2}, DWIDTH-bit signed each
//            res_val_i    per-channel result sample strobe
//            res_data_i   channel c at [c*4*(DWIDTH+1) +: 4*(DWIDTH+1)],
//                         packed {xr,yr}, 2*(DWIDTH+1) bits each
//            err_any_o    sticky: any mismatch/underflow/overflow
//            err_ch_o     sticky per-channel mismatch or underflow
//            ovf_o        sticky: push attempted while the queue was full
//            chk_cnt_o    checks performed (saturating)
//            err_cnt_o    mismatches + underflows (saturating)
//            level_o      occupancy seen by the slowest channel
// Config   : COMP_MULT_SB_STOP_EN - when defined, every error prints a
//            report and calls $stop, every good check prints a GOOD line.
//            Port behaviour is identical in both builds.
// Revision : 1.0 - initial release
//============================================================================
module comp_mult_scoreboard #(
    parameter int DWIDTH = 8,
    parameter int NCH    = 3,
    parameter int AW     = 6,
    parameter int CW     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sw_rst_i,
    input  logic                        op_val_i,
    input  logic                        op_rdy_i,
    input  logic [4*DWIDTH-1:0]         op_data_i,
    input  logic [NCH-1:0]              res_val_i,
    input  logic [NCH*4*(DWIDTH+1)-1:0] res_data_i,
    output logic                        err_any_o,
    output logic [NCH-1:0]              err_ch_o,
    output logic                        ovf_o,
    output logic [CW-1:0]               chk_cnt_o,
    output logic [CW-1:0]               err_cnt_o,
    output logic [AW:0]                 level_o
);

    localparam int          c_DEPTH = 2**AW;
    localparam int          c_PW    = 2*(DWIDTH+1);    // one result component
    localparam int          c_RW    = 2*c_PW;          // one channel {xr,yr}
    localparam int          c_NW    = $clog2(NCH+1);   // per-cycle event count
    localparam logic [AW:0] c_FULL  = (AW+1)'(c_DEPTH);
    localparam logic [AW:0] c_ONE   = (AW+1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*DWIDTH-1:0] mem_q [c_DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q [NCH];
    logic [AW:0]         rd_ptr_d [NCH];
    logic [NCH-1:0]      err_ch_q, err_ch_d;
    logic                err_any_q, err_any_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       chk_cnt_q, chk_cnt_d;
    logic [CW-1:0]       err_cnt_q, err_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [AW:0]              w_pend [NCH];
    logic [4*DWIDTH-1:0]      w_entry [NCH];
    logic signed [c_PW-1:0]   w_xr_exp [NCH];
    logic signed [c_PW-1:0]   w_yr_exp [NCH];
    logic [AW:0]              w_level;
    logic                     w_full;
    logic                     w_push;
    logic                     w_wr_en;
    logic [NCH-1:0]           w_empty;
    logic [NCH-1:0]           w_smp;
    logic [NCH-1:0]           w_undf;
    logic [NCH-1:0]           w_mism;
    logic [c_NW-1:0]          w_n_chk;
    logic [c_NW-1:0]          w_n_err;
    logic [CW:0]              w_chk_sum;
    logic [CW:0]              w_err_sum;

    assign w_push  = op_val_i & op_rdy_i;
    assign w_full  = (w_level == c_FULL);
    // A push while full is dropped; sw_rst also suppresses the write.
    assign w_wr_en = w_push & ~w_full & ~sw_rst_i;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [c_PW-1:0] w_x1, w_y1, w_x2, w_y2;
        logic [c_PW-1:0]        w_dut_xr, w_dut_yr;

        assign w_entry[c] = mem_q[rd_ptr_q[c][AW-1:0]];

        // Sign-extend each operand to the result width so the products and
        // the sum/difference are exact without any overflow handling.
        assign w_x1 = {{(c_PW-DWIDTH){w_entry[c][4*DWIDTH-1]}}, w_entry[c][4*DWIDTH-1 -: DWIDTH]};
        assign w_y1 = {{(c_PW-DWIDTH){w_entry[c][3*DWIDTH-1]}}, w_entry[c][3*DWIDTH-1 -: DWIDTH]};
        assign w_x2 = {{(c_PW-DWIDTH){w_entry[c][2*DWIDTH-1]}}, w_entry[c][2*DWIDTH-1 -: DWIDTH]};
        assign w_y2 = {{(c_PW-DWIDTH){w_entry[c][DWIDTH-1]}},   w_entry[c][DWIDTH-1 -: DWIDTH]};

        assign w_xr_exp[c] = w_x1 * w_x2 - w_y1 * w_y2;
        assign w_yr_exp[c] = w_x1 * w_y2 + w_y1 * w_x2;

        assign w_dut_xr = res_data_i[c*c_RW + c_PW +: c_PW];
        assign w_dut_yr = res_data_i[c*c_RW +: c_PW];

        // Pointer difference wraps naturally in AW+1 bits.
        assign w_pend[c]  = wr_ptr_q - rd_ptr_q[c];
        assign w_empty[c] = (w_pend[c] == '0);
        assign w_smp[c]   = res_val_i[c] & ~w_empty[c];
        assign w_undf[c]  = res_val_i[c] &  w_empty[c];
        // Case inequality: an X/Z bit on the DUT side counts as a mismatch.
        assign w_mism[c]  = w_smp[c] & ((w_dut_xr !== w_xr_exp[c]) |
                                        (w_dut_yr !== w_yr_exp[c]));
    end

    // Occupancy of the slowest consumer.
    always_comb begin
        w_level = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_pend[c] > w_level) begin
                w_level = w_pend[c];
            end
        end
    end

    // Per-cycle event counts for the saturating counters.
    always_comb begin
        w_n_chk = '0;
        w_n_err = '0;
        for (int c = 0; c < NCH; c++) begin
            w_n_chk = w_n_chk + c_NW'(res_val_i[c]);
            w_n_err = w_n_err + c_NW'(w_mism[c] | w_undf[c]);
        end
    end

    assign w_chk_sum = {1'b0, chk_cnt_q} + (CW+1)'(w_n_chk);
    assign w_err_sum = {1'b0, err_cnt_q} + (CW+1)'(w_n_err);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        err_ch_d  = err_ch_q;
        err_any_d = err_any_q;
        ovf_d     = ovf_q;
        chk_cnt_d = chk_cnt_q;
        err_cnt_d = err_cnt_q;
        for (int c = 0; c < NCH; c++) begin
            rd_ptr_d[c] = rd_ptr_q[c];
        end

        if (sw_rst_i) begin
            wr_ptr_d  = '0;
            err_ch_d  = '0;
            err_any_d = 1'b0;
            ovf_d     = 1'b0;
            chk_cnt_d = '0;
            err_cnt_d = '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr_d[c] = '0;
            end
        end else begin
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + c_ONE;
            end
            if (w_push && w_full) begin
                ovf_d     = 1'b1;
                err_any_d = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (w_smp[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + c_ONE;
                end
                if (w_mism[c] || w_undf[c]) begin
                    err_ch_d[c] = 1'b1;
                    err_any_d   = 1'b1;
                end
            end
            chk_cnt_d = w_chk_sum[CW] ? '1 : w_chk_sum[CW-1:0];
            err_cnt_d = w_err_sum[CW] ? '1 : w_err_sum[CW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= op_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            err_ch_q  <= '0;
            err_any_q <= 1'b0;
            ovf_q     <= 1'b0;
            chk_cnt_q <= '0;
            err_cnt_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr_q[c] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            err_ch_q  <= err_ch_d;
            err_any_q <= err_any_d;
            ovf_q     <= ovf_d;
            chk_cnt_q <= chk_cnt_d;
            err_cnt_q <= err_cnt_d;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

    assign err_any_o = err_any_q;
    assign err_ch_o  = err_ch_q;
    assign ovf_o     = ovf_q;
    assign chk_cnt_o = chk_cnt_q;
    assign err_cnt_o = err_cnt_q;
    assign level_o   = w_level;

`ifdef COMP_MULT_SB_STOP_EN
    // Interactive reporting: describe every event, halt on any error.
    always @(posedge clk) begin
        if (rst_n && !sw_rst_i) begin
            if (w_push && w_full) begin
                $display("%m t=%0t overflow: push dropped, operands=%h", $time, op_data_i);
                $stop;
            end
            for (int c = 0; c < NCH; c++) begin
                if (w_undf[c]) begin
                    $display("%m t=%0t ch=%0d underflow: sample with empty queue, dut=%h",
                             $time, c, res_data_i[c*c_RW +: c_RW]);
                    $stop;
                end else if (w_mism[c]) begin
                    $display("%m t=%0t ch=%0d wrong result: operands=%h dut=%h exp=%h",
                             $time, c, w_entry[c], res_data_i[c*c_RW +: c_RW],
                             {w_xr_exp[c], w_yr_exp[c]});
                    $stop;
                end else if (w_smp[c]) begin
                    $display("%m t=%0t ch=%0d GOOD operands=%h result=%h",
                             $time, c, w_entry[c], res_data_i[c*c_RW +: c_RW]);
                end
            end
        end
    end
`else
    // Silent build: status is visible through the output ports only.
`endif

endmodule
`default_nettype wire

// File: tb/tb_comp_mult_scoreboard.sv
`default_nettype none
//============================================================================
// Module   : tb_comp_mult_scoreboard
// Purpose  : Self-checking bench for comp_mult_scoreboard (DWIDTH=8, NCH=3,
//            AW=6, CW=16). A directed vector table, hand-written multi-cycle
//            sequences and randomized traffic, all compared against an
//            operand-history reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_comp_mult_scoreboard;

    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int AW  = 6;
    localparam int CW  = 16;
    localparam int RW  = 4*(DW+1);
    localparam int MAXC = 65535;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sw_rst_i = 1'b0;
    logic                op_val_i = 1'b0;
    logic                op_rdy_i = 1'b0;
    logic [4*DW-1:0]     op_data_i = '0;
    logic [NCH-1:0]      res_val_i = '0;
    logic [NCH*RW-1:0]   res_data_i = '0;
    logic                err_any_o;
    logic [NCH-1:0]      err_ch_o;
    logic                ovf_o;
    logic [CW-1:0]       chk_cnt_o;
    logic [CW-1:0]       err_cnt_o;
    logic [AW:0]         level_o;

    always #5 clk = ~clk;

    comp_mult_scoreboard #(.DWIDTH(DW), .NCH(NCH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_i(sw_rst_i),
        .op_val_i(op_val_i), .op_rdy_i(op_rdy_i), .op_data_i(op_data_i),
        .res_val_i(res_val_i), .res_data_i(res_data_i),
        .err_any_o(err_any_o), .err_ch_o(err_ch_o), .ovf_o(ovf_o),
        .chk_cnt_o(chk_cnt_o), .err_cnt_o(err_cnt_o), .level_o(level_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Every accepted operand set is kept in hist; a channel's position is
    // simply how many sets it has consumed.
    logic [31:0] hist[$];
    int          rd[NCH];
    bit [2:0]    m_errch;
    bit          m_any, m_ovf;
    int          m_chk, m_err;

    function automatic logic [31:0] ops(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    function automatic logic [35:0] exp_pack(input logic [31:0] d);
        logic signed [31:0] x1, y1, x2, y2, xr, yr;
        x1 = $signed(d[31:24]);
        y1 = $signed(d[23:16]);
        x2 = $signed(d[15:8]);
        y2 = $signed(d[7:0]);
        xr = x1*x2 - y1*y2;
        yr = x1*y2 + y1*x2;
        return {xr[17:0], yr[17:0]};
    endfunction

    function automatic int pend(input int c);
        return hist.size() - rd[c];
    endfunction

    function automatic int mlevel();
        int m = 0;
        for (int c = 0; c < NCH; c++) if (pend(c) > m) m = pend(c);
        return m;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic void model_clear();
        hist.delete();
        for (int c = 0; c < NCH; c++) rd[c] = 0;
        m_errch = '0; m_any = 0; m_ovf = 0; m_chk = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit sr, input bit push, input logic [31:0] d,
                                       input bit [2:0] rv, input logic [NCH*RW-1:0] rdat);
        bit full;
        if (sr) begin
            model_clear();
            return;
        end
        full = (mlevel() == 64);
        for (int c = 0; c < NCH; c++) begin
            if (rv[c]) begin
                m_chk = sat(m_chk + 1);
                if (pend(c) == 0) begin
                    m_err = sat(m_err + 1); m_errch[c] = 1'b1; m_any = 1'b1;
                end else begin
                    if (rdat[c*RW +: RW] != exp_pack(hist[rd[c]])) begin
                        m_err = sat(m_err + 1); m_errch[c] = 1'b1; m_any = 1'b1;
                    end
                    rd[c]++;
                end
            end
        end
        if (push) begin
            if (full) begin m_ovf = 1'b1; m_any = 1'b1; end
            else hist.push_back(d);
        end
    endfunction

    // Correct response for every channel's next pending entry (zero if empty).
    function automatic logic [NCH*RW-1:0] good_all();
        logic [NCH*RW-1:0] r = '0;
        for (int c = 0; c < NCH; c++)
            if (pend(c) > 0) r[c*RW +: RW] = exp_pack(hist[rd[c]]);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("err_ch",  err_ch_o,  m_errch);
        check("err_any", err_any_o, m_any);
        check("ovf",     ovf_o,     m_ovf);
        check("chk_cnt", chk_cnt_o, m_chk);
        check("err_cnt", err_cnt_o, m_err);
        check("level",   level_o,   mlevel());
    endtask

    // One clock: apply inputs, advance model, check outputs 1 ns after the edge.
    task automatic cyc(input bit sr, input bit pv, input bit pr, input logic [31:0] d,
                       input bit [2:0] rv, input logic [NCH*RW-1:0] rdat);
        sw_rst_i = sr; op_val_i = pv; op_rdy_i = pr; op_data_i = d;
        res_val_i = rv; res_data_i = rdat;
        model_step(sr, pv & pr, d, rv, rdat);
        @(posedge clk); #1;
        sw_rst_i = 1'b0; op_val_i = 1'b0; res_val_i = '0;
        check_model();
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, '0, '0);
    endtask

    task automatic push(input logic [31:0] d);
        cyc(0, 1, 1, d, '0, '0);
    endtask

    task automatic samp(input bit [2:0] rv);
        cyc(0, 0, 0, '0, rv, good_all());
    endtask

    task automatic swrst();
        cyc(1, 0, 0, '0, '0, '0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       sr;
        bit       pv;
        int       x1, y1, x2, y2;
        bit [2:0] rv;
        int       rxr, ryr;
        bit [2:0] e_errch;
        int       e_chk, e_err, e_lvl;
        bit       e_any, e_ovf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [NCH*RW-1:0] rdat;
        logic [31:0]       vx, vy;
        logic [35:0]       bad;

        // sr pv  x1   y1   x2   y2  rv     rxr  ryr   errch  chk err lvl any ovf
        tbl[0]  = '{0, 1,   3,   4,   1,   2, 3'b000,  0,   0,     3'b000, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0,   0,   0,   0,   0, 3'b111, -5,  10,     3'b000, 3, 0, 0, 0, 0};
        tbl[2]  = '{0, 1,-128,-128,-128,-128, 3'b000,  0,   0,     3'b000, 3, 0, 1, 0, 0};
        tbl[3]  = '{0, 0,   0,   0,   0,   0, 3'b001,  0, 32768,   3'b000, 4, 0, 1, 0, 0};
        tbl[4]  = '{0, 0,   0,   0,   0,   0, 3'b010,  0, 32768,   3'b000, 5, 0, 1, 0, 0};
        tbl[5]  = '{0, 0,   0,   0,   0,   0, 3'b100,  0, 32768,   3'b000, 6, 0, 0, 0, 0};
        tbl[6]  = '{0, 1,   3,   4,   1,   2, 3'b000,  0,   0,     3'b000, 6, 0, 1, 0, 0};
        tbl[7]  = '{0, 0,   0,   0,   0,   0, 3'b101, -5,  10,     3'b000, 8, 0, 1, 0, 0};
        tbl[8]  = '{0, 0,   0,   0,   0,   0, 3'b010, -5,  11,     3'b010, 9, 1, 0, 1, 0};
        tbl[9]  = '{0, 0,   0,   0,   0,   0, 3'b100,  0,   0,     3'b110,10, 2, 0, 1, 0};
        tbl[10] = '{0, 1,   5,  -7,  -2,   3, 3'b100, 11,  29,     3'b110,11, 3, 1, 1, 0};
        tbl[11] = '{0, 0,   0,   0,   0,   0, 3'b111, 11,  29,     3'b110,14, 3, 0, 1, 0};
        tbl[12] = '{1, 1,   3,   4,   1,   2, 3'b111, -5,  10,     3'b000, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0,   0,   0,   0,   0, 3'b000,  0,   0,     3'b000, 0, 0, 0, 0, 0};

        model_clear();

        // Reset state while rst_n is held low.
        #23;
        check("rst_err_any", err_any_o, 0);
        check("rst_err_ch",  err_ch_o,  0);
        check("rst_ovf",     ovf_o,     0);
        check("rst_chk_cnt", chk_cnt_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_level",   level_o,   0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_model();

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            rdat = '0;
            vx = tbl[i].rxr;
            vy = tbl[i].ryr;
            for (int c = 0; c < NCH; c++)
                if (tbl[i].rv[c]) rdat[c*RW +: RW] = {vx[17:0], vy[17:0]};
            cyc(tbl[i].sr, tbl[i].pv, 1'b1, ops(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2),
                tbl[i].rv, rdat);
            check($sformatf("tbl%0d_err_ch", i),  err_ch_o,  tbl[i].e_errch);
            check($sformatf("tbl%0d_chk_cnt", i), chk_cnt_o, tbl[i].e_chk);
            check($sformatf("tbl%0d_err_cnt", i), err_cnt_o, tbl[i].e_err);
            check($sformatf("tbl%0d_level", i),   level_o,   tbl[i].e_lvl);
            check($sformatf("tbl%0d_err_any", i), err_any_o, tbl[i].e_any);
            check($sformatf("tbl%0d_ovf", i),     ovf_o,     tbl[i].e_ovf);
        end

        // Channels consume one entry at widely different times.
        swrst();
        push(ops(-128, -128, -128, -128));
        for (int t = 1; t <= 20; t++) begin
            if (t == 5)       samp(3'b001);
            else if (t == 9)  samp(3'b010);
            else if (t == 20) begin
                check("spaced_level_hold", level_o, 1);
                samp(3'b100);
            end else idle();
        end
        check("spaced_level_end", level_o, 0);
        check("spaced_chk_cnt",   chk_cnt_o, 3);
        check("spaced_err_any",   err_any_o, 0);

        // Underflow on ch2, then a valid push/sample on ch2 passes.
        swrst();
        samp(3'b100);
        check("undf_err_ch",  err_ch_o,  3'b100);
        check("undf_err_cnt", err_cnt_o, 1);
        check("undf_level",   level_o,   0);
        push(ops(7, -3, 2, 9));
        samp(3'b100);
        check("undf_after_err_cnt", err_cnt_o, 1);
        check("undf_after_chk_cnt", chk_cnt_o, 2);

        // Overflow: 64 accepted, 65th dropped.
        swrst();
        for (int i = 0; i < 64; i++) push($urandom);
        push(32'hA5A5_A5A5);
        check("ovf_flag",    ovf_o,     1);
        check("ovf_level",   level_o,   64);
        check("ovf_err_any", err_any_o, 1);
        check("ovf_err_cnt", err_cnt_o, 0);
        for (int i = 0; i < 64; i++) samp(3'b111);
        check("ovf_drain_chk", chk_cnt_o, 192);
        check("ovf_drain_err", err_cnt_o, 0);
        samp(3'b001);
        check("ovf_65th_absent", err_ch_o, 3'b001);

        // Fill to 40, one mismatch, sw_rst with concurrent push.
        swrst();
        for (int i = 0; i < 40; i++) push($urandom);
        rdat = good_all();
        rdat[RW] = ~rdat[RW];
        cyc(0, 0, 0, '0, 3'b010, rdat);
        check("fill_err_cnt", err_cnt_o, 1);
        check("fill_level",   level_o,   40);
        cyc(1, 1, 1, $urandom, 3'b111, good_all());
        check("swrst_err_any", err_any_o, 0);
        check("swrst_err_ch",  err_ch_o,  0);
        check("swrst_chk_cnt", chk_cnt_o, 0);
        check("swrst_level",   level_o,   0);
        idle();
        check("swrst_push_ignored", level_o, 0);

        // Asynchronous rst_n drop mid-stream.
        for (int i = 0; i < 10; i++) push($urandom);
        rdat = good_all();
        rdat[0] = ~rdat[0];
        cyc(0, 0, 0, '0, 3'b001, rdat);
        check("pre_arst_err_cnt", err_cnt_o, 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("arst_err_any", err_any_o, 0);
        check("arst_err_ch",  err_ch_o,  0);
        check("arst_chk_cnt", chk_cnt_o, 0);
        check("arst_err_cnt", err_cnt_o, 0);
        check("arst_level",   level_o,   0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_model();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit          sr, pv, pr;
            bit [2:0]    rv;
            logic [31:0] d;
            sr = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            for (int c = 0; c < NCH; c++) rv[c] = ($urandom_range(0, 2) == 0);
            rdat = good_all();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    bad = rdat[c*RW +: RW];
                    bad[$urandom_range(0, 35)] ^= 1'b1;
                    rdat[c*RW +: RW] = bad;
                end
            end
            cyc(sr, pv, pr, d, rv, rdat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
